// File: rtl/oport_uart_tx_pkg.sv
// ============================================================================
// oport_uart_tx_pkg : FSM encodings and build constants for the output-port UART.
// Optional macro OPORT_UART_PARITY_EN adds an even-parity bit to each frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

package oport_uart_tx_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_CLKS_PER_BIT = 16;

`ifdef OPORT_UART_PARITY_EN
  localparam int UART_FRAME_BITS = 9;
`else
  localparam int UART_FRAME_BITS = 8;
`endif

endpackage

`default_nettype wire

// File: rtl/oport_uart_tx_sync_fifo.sv
// ============================================================================
// sync_fifo : show-ahead synchronous FIFO (dout valid whenever empty=0).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push while full is still taken.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/oport_uart_tx.sv
// ============================================================================
// oport_uart_tx : buffers output-port writes and sends them as 8N1 UART frames.
// Optional macro OPORT_UART_PARITY_EN appends an even-parity bit (8E1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module oport_uart_tx
  import oport_uart_tx_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int FB     = UART_FRAME_BITS;

  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        LAST_BIT = 4'(FB - 1);

  uart_state_t       state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [FB-1:0]     shift, shift_n;
  logic [FB-1:0]     frame_load;
  logic              tx_n;
  logic              baud_last;
  logic              pop;

  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PTR_W:0]    fifo_count;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Parity rides as the top bit of the shift register, sent after data bit 7.
`ifdef OPORT_UART_PARITY_EN
  assign frame_load = {^fifo_dout, fifo_dout};
`else
  assign frame_load = fifo_dout;
`endif

  assign baud_last = (baud == BAUD_MAX);
  assign busy      = (state != UART_IDLE) || (fifo_count != '0);
  assign full      = fifo_full;

  always_comb begin
    state_n   = state;
    baud_n    = baud_last ? '0 : baud + BAUD_W'(1);
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      UART_IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_n   = frame_load;
          bit_cnt_n = '0;
          state_n   = UART_START;
          tx_n      = 1'b0;
        end
      end
      UART_START: begin
        if (baud_last) begin
          state_n = UART_DATA;
          tx_n    = shift[0];
        end
      end
      UART_DATA: begin
        if (baud_last) begin
          if (bit_cnt == LAST_BIT) begin
            state_n = UART_STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n   = shift >> 1;
            bit_cnt_n = bit_cnt + 4'd1;
            tx_n      = shift[1];
          end
        end
      end
      UART_STOP: begin
        if (baud_last) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_n   = frame_load;
            bit_cnt_n = '0;
            state_n   = UART_START;
            tx_n      = 1'b0;
          end else begin
            state_n = UART_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = UART_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= UART_IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      tx      <= tx_n;
      if (wr && fifo_full && !pop) overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oport_uart_tx.sv
// ============================================================================
// tb_oport_uart_tx : directed self-checking bench for oport_uart_tx (CLKS_PER_BIT=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_oport_uart_tx;

  localparam int CPB = 4;
`ifdef OPORT_UART_PARITY_EN
  localparam int SLOTS = 11;
`else
  localparam int SLOTS = 10;
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       wr      = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  oport_uart_tx #(
    .DEPTH        (4),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr       (wr),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push1(input logic [7:0] d);
    wr_data = d;
    wr      = 1'b1;
    tick();
    wr      = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(tx), 32'd0);
  endtask

  // Called just after the edge that drove the start bit; consumes one whole frame.
  task automatic check_frame(input string tag, input logic [7:0] b, input bit full_low);
    logic [10:0] fr;
    fr = {2'b11, b, 1'b0};
`ifdef OPORT_UART_PARITY_EN
    fr[9] = ^b;
`endif
    for (int c = 0; c < SLOTS * CPB; c++) begin
      chk({tag, "_tx"}, 32'(tx), 32'(fr[c / CPB]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (full_low) chk({tag, "_full"}, 32'(full), 32'd0);
      tick();
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b1;
    tick();

    // Single byte and push-to-start latency
    push1(8'hA5);
    chk("lat_n_tx", 32'(tx), 32'd1);
    chk("lat_n_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_n1_tx", 32'(tx), 32'd0);
    check_frame("a5", 8'hA5, 1'b1);
    chk("a5_end_busy", 32'(busy), 32'd0);
    chk("a5_end_tx", 32'(tx), 32'd1);

    // Back-to-back frames, no gap, never full
    fork
      begin
        wr = 1'b1;
        wr_data = 8'h01; tick();
        wr_data = 8'h02; tick();
        wr_data = 8'h03; tick();
        wr = 1'b0;
      end
      begin
        wait_start("b2b_start");
        check_frame("b2b_01", 8'h01, 1'b1);
        check_frame("b2b_02", 8'h02, 1'b1);
        check_frame("b2b_03", 8'h03, 1'b1);
      end
    join
    chk("b2b_end_busy", 32'(busy), 32'd0);

    // Push coinciding with the STOP->START pop while full
    fork
      begin
        wr = 1'b1;
        wr_data = 8'h3C; tick();
        wr_data = 8'h81; tick();
        wr_data = 8'h42; tick();
        wr_data = 8'h24; tick();
        wr_data = 8'h18; tick();
        wr = 1'b0;
        chk("ppf_full", 32'(full), 32'd1);
        chk("ppf_ovf0", 32'(overflow), 32'd0);
        repeat (SLOTS * CPB - 4) tick();
        chk("ppf_full_pre", 32'(full), 32'd1);
        wr = 1'b1;
        wr_data = 8'hE7;
        tick();
        wr = 1'b0;
        chk("ppf_ovf1", 32'(overflow), 32'd0);
        chk("ppf_full_post", 32'(full), 32'd1);
      end
      begin
        wait_start("ppf_start");
        check_frame("ppf_3c", 8'h3C, 1'b0);
        check_frame("ppf_81", 8'h81, 1'b0);
        check_frame("ppf_42", 8'h42, 1'b0);
        check_frame("ppf_24", 8'h24, 1'b0);
        check_frame("ppf_18", 8'h18, 1'b0);
        check_frame("ppf_e7", 8'hE7, 1'b0);
      end
    join
    chk("ppf_end_ovf", 32'(overflow), 32'd0);
    chk("ppf_end_busy", 32'(busy), 32'd0);

    // Overflow: six consecutive pushes from idle, the sixth is dropped
    fork
      begin
        wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
          wr_data = 8'(8'h10 + i);
          tick();
        end
        wr = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_full", 32'(full), 32'd1);
      end
      begin
        wait_start("ovf_start");
        for (int k = 0; k < 5; k++) check_frame("ovf_frame", 8'(8'h10 + k), 1'b0);
      end
    join
    chk("ovf_end_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    chk("ovf_idle_tx", 32'(tx), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset during data bit 3 of 0x00
    push1(8'h00);
    wait_start("arst_start");
    repeat (17) tick();
    chk("arst_pre_tx", 32'(tx), 32'd0);
    chk("arst_pre_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    push1(8'hFF);
    wait_start("ff_start");
    check_frame("ff", 8'hFF, 1'b1);
    chk("ff_end_busy", 32'(busy), 32'd0);

    // Parity-sensitive bytes (odd and even popcount)
    push1(8'h07);
    wait_start("p07_start");
    check_frame("p07", 8'h07, 1'b1);
    chk("p07_end_busy", 32'(busy), 32'd0);
    push1(8'h03);
    wait_start("p03_start");
    check_frame("p03", 8'h03, 1'b1);
    chk("p03_end_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/oport_uart_tx.md
Name: oport_uart_tx

Overview:
Downstream consumer of the output-port register. Every pulse of the output-port write strobe (c_go qualified with internal_clk) pushes the current 8-bit port value into a small FIFO. A UART transmitter drains the FIFO as 8N1 frames on a single serial line, so program output leaves the board without logic-analyser probing of oport. The block sits beside the out0 register and taps the same data_bus/c_go signals.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2
PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
wr_data  input  8  byte to transmit (output-port value)
wr  input  1  single-cycle push strobe, sampled on rising clk
tx  output  1  serial line, idles high
busy  output  1  high while a frame is on the line or FIFO non-empty
full  output  1  FIFO holds DEPTH entries
overflow  output  1  sticky: a push arrived while full and was dropped

Behaviour:
- Reset (reset=0, asynchronous): tx=1, busy=0, full=0, overflow=0, FIFO empty, FSM=IDLE, counters zero. Reset mid-frame aborts the frame immediately and tx returns high without waiting for a clock.
- Push: wr=1 and not full at edge N stores wr_data. Pointers wrap modulo DEPTH. The count is PTR_W+1 bits wide.
- Full: wr=1 while full with no pop in the same cycle drops the byte and sets overflow. overflow is cleared only by reset.
- Simultaneous push and pop while full: the pop frees a slot, the push is accepted, and overflow is not set.
- Simultaneous push and pop while empty: not possible, because a pop requires non-empty at the edge. The pushed byte pops on the next edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty at edge E, pop the head into the shift register, clear the bit counter, go to START. tx=0 is visible after edge E.
  - Latency: a byte pushed into an empty FIFO while IDLE at edge N drives tx low after edge N+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. After bit 7 (or after the parity bit, see Optional Feature), go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Back-to-back frames take exactly 10*CLKS_PER_BIT cycles each (11* with parity).
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. It is zeroed on every state entry.
- busy = (state != IDLE) | (count != 0). full = (count == DEPTH). Both are combinational from registers.
- tx is driven directly from a flop; no combinational path from wr to tx.

Optional Feature:
Macro OPORT_UART_PARITY_EN.
- Defined: the frame adds an even-parity bit (XOR of the 8 data bits) after bit 7, held CLKS_PER_BIT cycles. Frame length is 11*CLKS_PER_BIT.
- Undefined: no parity logic is present and the frame is 8N1, 10*CLKS_PER_BIT.
- Port list is identical in both builds.

Decomposition:
- symbols.vh gains the FSM state encodings UART_IDLE=2'd0, UART_START=2'd1, UART_DATA=2'd2, UART_STOP=2'd3, and the default UART_CLKS_PER_BIT.
- One sub-module: sync_fifo (parameters DEPTH, WIDTH=8; ports clk, reset, push, pop, din, dout, full, empty, count). The FIFO reads show-ahead: dout is valid whenever empty=0.
- The transmitter FSM, baud counter and shift register live in oport_uart_tx.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
- Single byte: push 0xA5 into an idle block → tx, in 4-cycle slots, is 0 | 1,0,1,0,0,1,0,1 | 1. busy falls exactly 40 cycles after tx first goes low.
- Back-to-back: push 0x01, 0x02, 0x03 on consecutive cycles → three contiguous frames, 120 cycles with no high gap between the stop bit and the next start bit. full is never asserted.
- Overflow: with DEPTH=4, push 6 bytes on consecutive cycles starting while idle → the first byte pops at once, so 5 are accepted and 1 is dropped. overflow=1 and stays 1 through subsequent frames.
- Push and pop while full: fill the FIFO during a frame, then pulse wr on the STOP→START pop edge → byte accepted, overflow stays 0, and the byte appears 4 frames later.
- Async reset mid-DATA: assert reset between clock edges during bit 3 of 0x00 → tx=1 immediately. busy, full and overflow read 0. After release, a push of 0xFF transmits a clean frame.
- Parity build (OPORT_UART_PARITY_EN): push 0x07 → parity slot = 1, frame 44 cycles. Push 0x03 → parity slot = 0.
